// File: rtl/a51_pkg.sv
// Shared constants, phase encoding and clocking-majority helper for the A5/1 frame sequencer.
package a51_pkg;

  localparam int unsigned KEY_LEN   = 64;
  localparam int unsigned FRAME_LEN = 22;
  localparam int unsigned MIX_LEN   = 100;
  localparam int unsigned OUT_LEN   = 228;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_LOAD_KEY   = 3'd1,
    PH_LOAD_FRAME = 3'd2,
    PH_MIX        = 3'd3,
    PH_OUTPUT     = 3'd4,
    PH_DONE       = 3'd5
  } phase_e;

  function automatic logic maj3(input logic [2:0] b);
    return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
  endfunction

endpackage

// File: rtl/a51_clk_maj.sv
// A5/1 majority clocking rule: an LFSR steps when its clocking tap agrees with the majority.
module a51_clk_maj
  import a51_pkg::*;
(
  input  logic [2:0] CLKBIT,
  output logic [2:0] CLK_EN
);

  logic w_maj;

  assign w_maj  = maj3(CLKBIT);
  assign CLK_EN = ~(CLKBIT ^ {3{w_maj}});

endmodule

// File: rtl/a51_keystream_ctrl.sv
// A5/1 frame sequencer: key load, frame load, mixing and keystream phases over one counter.
// Optional build macro A51_DUPLEX_EN inserts a one-cycle bubble between downlink and uplink halves.
module a51_keystream_ctrl
  import a51_pkg::*;
(
  input  logic                 C,
  input  logic                 CLR_N,
  input  logic                 START,
  input  logic                 ENABLE,
  input  logic [KEY_LEN-1:0]   KEY,
  input  logic [FRAME_LEN-1:0] FRAME,
  input  logic [2:0]           CLKBIT,
  output logic [2:0]           CLK_EN,
  output logic                 IN_BIT,
  output logic                 KS_VALID,
  output logic                 KS_DIR,
  output logic [2:0]           PHASE,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned KEY_IW   = $clog2(KEY_LEN);
  localparam int unsigned FRAME_IW = $clog2(FRAME_LEN);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_HALF   = CNT_W'(OUT_LEN / 2);

  phase_e           r_state;
  phase_e           w_state_nxt;
  phase_e           w_succ;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_bubble;
  logic [2:0]       w_maj_en;

  a51_clk_maj u_clk_maj (
    .CLKBIT (CLKBIT),
    .CLK_EN (w_maj_en)
  );

`ifdef A51_DUPLEX_EN
  logic r_bub_done;
  logic w_bub_done_nxt;

  // The bubble sits at CNT==OUT_LEN/2 and is consumed once; CNT holds across it.
  assign w_bubble = (r_state == PH_OUTPUT) && (r_cnt == OUT_HALF) && !r_bub_done;
`else
  assign w_bubble = 1'b0;
`endif

  always_comb begin
    w_last = 1'b0;
    w_succ = PH_IDLE;
    case (r_state)
      PH_LOAD_KEY: begin
        w_last = (r_cnt == KEY_LAST);
        w_succ = PH_LOAD_FRAME;
      end
      PH_LOAD_FRAME: begin
        w_last = (r_cnt == FRAME_LAST);
        w_succ = PH_MIX;
      end
      PH_MIX: begin
        w_last = (r_cnt == MIX_LAST);
        w_succ = PH_OUTPUT;
      end
      PH_OUTPUT: begin
        w_last = (r_cnt == OUT_LAST);
        w_succ = PH_DONE;
      end
      default: begin
        w_last = 1'b0;
        w_succ = PH_IDLE;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef A51_DUPLEX_EN
    w_bub_done_nxt = r_bub_done;
`endif
    case (r_state)
      PH_IDLE, PH_DONE: begin
        if (START) begin
          w_state_nxt = PH_LOAD_KEY;
          w_cnt_nxt   = '0;
`ifdef A51_DUPLEX_EN
          w_bub_done_nxt = 1'b0;
`endif
        end
      end
      PH_LOAD_KEY, PH_LOAD_FRAME, PH_MIX, PH_OUTPUT: begin
        if (ENABLE) begin
          if (w_bubble) begin
`ifdef A51_DUPLEX_EN
            w_bub_done_nxt = 1'b1;
`endif
          end else if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_succ;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = PH_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (!CLR_N) begin
      r_state <= PH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef A51_DUPLEX_EN
  always_ff @(posedge C) begin
    if (!CLR_N) begin
      r_bub_done <= 1'b0;
    end else begin
      r_bub_done <= w_bub_done_nxt;
    end
  end
`endif

  always_comb begin
    CLK_EN   = '0;
    IN_BIT   = 1'b0;
    KS_VALID = 1'b0;
    KS_DIR   = 1'b0;
    case (r_state)
      PH_LOAD_KEY: begin
        CLK_EN = ENABLE ? '1 : '0;
        IN_BIT = KEY[r_cnt[KEY_IW-1:0]];
      end
      PH_LOAD_FRAME: begin
        CLK_EN = ENABLE ? '1 : '0;
        IN_BIT = FRAME[r_cnt[FRAME_IW-1:0]];
      end
      PH_MIX: begin
        CLK_EN = ENABLE ? w_maj_en : '0;
      end
      PH_OUTPUT: begin
        if (!w_bubble) begin
          CLK_EN   = ENABLE ? w_maj_en : '0;
          KS_VALID = ENABLE;
        end
`ifdef A51_DUPLEX_EN
        KS_DIR = (r_cnt >= OUT_HALF);
`endif
      end
      default: begin
        CLK_EN   = '0;
        IN_BIT   = 1'b0;
        KS_VALID = 1'b0;
      end
    endcase
  end

  assign PHASE = r_state;
  assign BUSY  = (r_state != PH_IDLE) && (r_state != PH_DONE);
  assign DONE  = (r_state == PH_DONE);

endmodule

// File: tb/tb_a51_keystream_ctrl.sv
// Self-checking bench for a51_keystream_ctrl; reference model tracks frame position as a step count.
module tb_a51_keystream_ctrl;

`ifdef A51_DUPLEX_EN
  localparam int DUPLEX = 1;
`else
  localparam int DUPLEX = 0;
`endif
  localparam int TOTAL = 64 + 22 + 100 + 228 + DUPLEX;

  logic        C;
  logic        CLR_N;
  logic        START;
  logic        ENABLE;
  logic [63:0] KEY;
  logic [21:0] FRAME;
  logic [2:0]  CLKBIT;
  logic [2:0]  CLK_EN;
  logic        IN_BIT;
  logic        KS_VALID;
  logic        KS_DIR;
  logic [2:0]  PHASE;
  logic        BUSY;
  logic        DONE;

  a51_keystream_ctrl dut (
    .C        (C),
    .CLR_N    (CLR_N),
    .START    (START),
    .ENABLE   (ENABLE),
    .KEY      (KEY),
    .FRAME    (FRAME),
    .CLKBIT   (CLKBIT),
    .CLK_EN   (CLK_EN),
    .IN_BIT   (IN_BIT),
    .KS_VALID (KS_VALID),
    .KS_DIR   (KS_DIR),
    .PHASE    (PHASE),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  int n_assert;
  int n_fail;
  int n_ksv;
  int n_inbit;
  int m_kind;   // 0 idle, 1 busy, 2 done
  int m_p;      // enabled steps taken since START

  logic [2:0] tbl_cb [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b001};
  logic [2:0] tbl_en [5] = '{3'b111, 3'b011, 3'b101, 3'b110, 3'b110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input int kind, input int p, output int ph,
                                 output int cnt, output int q, output bit bub);
    ph = 0; cnt = 0; q = 0; bub = 1'b0;
    if (kind == 0) ph = 0;
    else if (kind == 2) ph = 5;
    else if (p < 64) begin ph = 1; cnt = p; end
    else if (p < 86) begin ph = 2; cnt = p - 64; end
    else if (p < 186) begin ph = 3; cnt = p - 86; end
    else begin
      ph = 4;
      q = p - 186;
      bub = (DUPLEX == 1) && (q == 114);
    end
  endfunction

  task automatic step(input logic en, input logic st, input logic clrn,
                      input logic [2:0] cb, input int tbl_idx);
    int ph, cnt, q;
    bit bub;
    logic maj;
    logic [2:0] e_clk;
    logic e_in, e_ksv, e_dir;
    @(negedge C);
    ENABLE = en; START = st; CLR_N = clrn; CLKBIT = cb;
    #1;
    decode(m_kind, m_p, ph, cnt, q, bub);
    maj   = ($countones(cb) >= 2);
    e_clk = 3'b000;
    if (en && (ph == 1 || ph == 2)) e_clk = 3'b111;
    else if (en && (ph == 3 || (ph == 4 && !bub)))
      e_clk = {cb[2] == maj, cb[1] == maj, cb[0] == maj};
    e_in  = (ph == 1) ? KEY[cnt] : (ph == 2) ? FRAME[cnt] : 1'b0;
    e_ksv = en && (ph == 4) && !bub;
    e_dir = (DUPLEX == 1) && (ph == 4) && (q >= 114);
    chk("phase", 32'(PHASE), 32'(ph));
    chk("busy", 32'(BUSY), 32'(m_kind == 1));
    chk("done", 32'(DONE), 32'(m_kind == 2));
    chk("clk_en", 32'(CLK_EN), 32'(e_clk));
    chk("in_bit", 32'(IN_BIT), 32'(e_in));
    chk("ks_valid", 32'(KS_VALID), 32'(e_ksv));
    chk("ks_dir", 32'(KS_DIR), 32'(e_dir));
    if (tbl_idx >= 0) chk("maj_tbl", 32'(CLK_EN), 32'(tbl_en[tbl_idx]));
    if (KS_VALID === 1'b1) n_ksv++;
    if (IN_BIT === 1'b1 && BUSY === 1'b1) n_inbit++;
    @(posedge C);
    if (!clrn) begin
      m_kind = 0; m_p = 0;
    end else if (m_kind != 1) begin
      if (st) begin m_kind = 1; m_p = 0; end
    end else if (en) begin
      m_p++;
      if (m_p == TOTAL) m_kind = 2;
    end
  endtask

  function automatic logic [2:0] rcb();
    return 3'($urandom_range(7));
  endfunction

  initial begin
    int ph, cnt, q, e, done_edge;
    bit bub;
    n_assert = 0; n_fail = 0; n_ksv = 0; n_inbit = 0;
    m_kind = 0; m_p = 0;
    CLR_N = 1'b0; START = 1'b0; ENABLE = 1'b0; KEY = '0; FRAME = '0; CLKBIT = '0;
    @(posedge C);

    // reset held, then idle
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, rcb(), -1);
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'b0, 1'b1, rcb(), -1);

    // full frame, ENABLE high, directed load bits and majority table
    KEY = 64'h0000_0000_0000_0001;
    FRAME = 22'h200000;
    step(1'b1, 1'b1, 1'b1, rcb(), -1);
    n_ksv = 0; n_inbit = 0; done_edge = -1;
    for (e = 1; e <= 1000; e++) begin
      decode(m_kind, m_p, ph, cnt, q, bub);
      if (ph == 3 && cnt < 5) step(1'b1, 1'b0, 1'b1, tbl_cb[cnt], cnt);
      else step(1'b1, 1'b0, 1'b1, rcb(), -1);
      #1;
      if (DONE === 1'b1) begin done_edge = e; break; end
    end
    chk("full_done_edge", 32'(done_edge), 32'(TOTAL));
    chk("full_ks_count", 32'(n_ksv), 32'd228);
    chk("full_inbit_count", 32'(n_inbit), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, rcb(), -1);

    // random key/frame, ENABLE toggling every cycle
    KEY = {$urandom, $urandom};
    FRAME = 22'($urandom);
    step(1'b0, 1'b1, 1'b1, rcb(), -1);
    n_ksv = 0; done_edge = -1;
    for (e = 1; e <= 2000; e++) begin
      step(1'(e % 2), 1'b0, 1'b1, rcb(), -1);
      #1;
      if (DONE === 1'b1) begin done_edge = e; break; end
    end
    chk("stall_done_edge", 32'(done_edge), 32'(2 * TOTAL - 1));
    chk("stall_ks_count", 32'(n_ksv), 32'd228);

    // random ENABLE, reset at the 100th MIX step
    KEY = {$urandom, $urandom};
    FRAME = 22'($urandom);
    step(1'b1, 1'b1, 1'b1, rcb(), -1);
    for (int i = 0; i < 2000 && !(m_kind == 1 && m_p == 185); i++)
      step(1'($urandom), 1'b0, 1'b1, rcb(), -1);
    chk("abort_reached_mix", 32'(PHASE), 32'd3);
    step(1'b1, 1'b0, 1'b0, rcb(), -1);
    #1;
    chk("abort_idle", 32'(PHASE), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, rcb(), -1);

    // START while busy is ignored; restart from DONE clears DONE
    step(1'b1, 1'b1, 1'b1, rcb(), -1);
    for (int i = 0; i < 50; i++) step(1'($urandom), 1'b0, 1'b1, rcb(), -1);
    step(1'b1, 1'b1, 1'b1, rcb(), -1);
    step(1'b1, 1'b1, 1'b1, rcb(), -1);
    for (int i = 0; i < 1000 && m_kind != 2; i++) step(1'b1, 1'b0, 1'b1, rcb(), -1);
    #1;
    chk("midstart_done", 32'(DONE), 32'd1);
    step(1'b0, 1'b1, 1'b1, rcb(), -1);
    #1;
    chk("restart_done_low", 32'(DONE), 32'd0);
    chk("restart_phase", 32'(PHASE), 32'd1);
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 1'b1, rcb(), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
